pe_result_drain: RTL and testbench

Downstream drain for the vector PE chain. Captures each VECTOR-lane result vector (`c_ab`) leaving the last PE into a small vector FIFO. It then serializes the vector one lane per cycle onto a valid/ready stream toward the output buffer or writeback. This decouples the free-running PE array from a narrower, back-pressured consumer.

---
 rtl/pe_pkg.sv | 25 ++
 rtl/pe_vec_fifo.sv | 81 ++++++++
 rtl/pe_result_drain.sv | 116 +++++++++++
 tb/tb_pe_result_drain.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and default sizes for the vector PE chain and its result drain.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   PE_REG_WIDTH / PE_VECTOR  default lane width and lane count
//   lane_idx_t                index of one lane within a result vector
//   lane_vec_t                one result vector, lane 0 in the low slot
//   drain_state_e             drain head state (idle / draining)
package pe_pkg;

  localparam int PE_REG_WIDTH = 16;
  localparam int PE_VECTOR    = 8;

  typedef logic [$clog2(PE_VECTOR)-1:0] lane_idx_t;

  typedef logic [PE_VECTOR-1:0][PE_REG_WIDTH-1:0] lane_vec_t;

  // IDLE: nothing stored; DRAIN: a head vector is being serialized.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/pe_vec_fifo.sv
// Whole-vector FIFO: DEPTH slots, each holding one complete result vector.
// Latency: a push at edge N is visible at rd_data from edge N+1 when empty.
// Backpressure: full when DEPTH vectors stored; push while full / pop while empty are ignored.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous clear of pointers and level (priority over push/pop)
//   push/wr_data write one vector at the write pointer
//   pop          retire the head vector
//   rd_data      head vector (contents undefined while empty)
//   level        vectors currently stored
//   full/empty   level == DEPTH / level == 0
module pe_vec_fifo
  import pe_pkg::*;
#(
  parameter int REG_WIDTH = PE_REG_WIDTH,
  parameter int VECTOR    = PE_VECTOR,
  parameter int DEPTH     = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              push,
  input  logic [VECTOR-1:0][REG_WIDTH-1:0]  wr_data,
  input  logic                              pop,
  output logic [VECTOR-1:0][REG_WIDTH-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]            level,
  output logic                              full,
  output logic                              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [VECTOR-1:0][REG_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]                 wr_ptr;
  logic [PTR_W-1:0]                 rd_ptr;
  logic                             push_ok;
  logic                             pop_ok;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage has no reset: contents are only observed behind a valid level.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leaves level unchanged.
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pe_result_drain.sv
// Captures result vectors from the last PE and serializes them one lane per cycle.
// Latency: push at edge N -> lane 0 on out_data from edge N+1; VECTOR beats per vector, no bubbles.
// Backpressure: in_ready drops when DEPTH vectors are held (no pop pass-through); out_ready stalls hold outputs.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous clear; discards stored and partially drained vectors
//   in_valid/in_ready    vector handshake; in_data is the unpacked lane array, lane 0 first
//   out_valid/out_ready  lane handshake; out_data/out_lane/out_last describe the current beat
//   level                vectors stored, including a partially drained head
module pe_result_drain
  import pe_pkg::*;
#(
  parameter int REG_WIDTH = PE_REG_WIDTH,
  parameter int VECTOR    = PE_VECTOR,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [REG_WIDTH-1:0]        in_data [VECTOR],
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [REG_WIDTH-1:0]        out_data,
  output logic [$clog2(VECTOR)-1:0]   out_lane,
  output logic                        out_last,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int LANE_W = $clog2(VECTOR);
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  drain_state_e                     state;
  logic [LANE_W-1:0]                lane_cnt;
  logic [VECTOR-1:0][REG_WIDTH-1:0] in_vec;
  logic [VECTOR-1:0][REG_WIDTH-1:0] head_vec;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             push;
  logic                             beat;
  logic                             is_last;
  logic                             pop;

  // Lane array into the packed storage format, lane 0 in the low slot.
  always_comb begin
    in_vec = '0;
    for (int i = 0; i < VECTOR; i++) begin
      in_vec[i] = in_data[i];
    end
  end

  // Fullness alone gates the input: a pop in the same cycle does not free a
  // slot early, which keeps out_ready off the in_ready path.
  assign in_ready  = !fifo_full && !flush;
  assign out_valid = (state == ST_DRAIN);

  assign push    = in_valid && in_ready;
  assign beat    = out_valid && out_ready;
  assign is_last = (lane_cnt == LANE_W'(VECTOR - 1));
  assign pop     = beat && is_last && !fifo_empty;

  pe_vec_fifo #(
    .REG_WIDTH (REG_WIDTH),
    .VECTOR    (VECTOR),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push),
    .wr_data (in_vec),
    .pop     (pop),
    .rd_data (head_vec),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head control. The state mirrors (level != 0) but is held in its own
  // register so out_valid comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lane_cnt <= '0;
    end else if (flush) begin
      state    <= ST_IDLE;
      lane_cnt <= '0;
    end else begin
      if (beat) begin
        lane_cnt <= is_last ? '0 : lane_cnt + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (push) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last beat of the only stored vector with nothing arriving.
          if (pop && !push && (level == LVL_W'(1))) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are zeroed when idle so an empty drain never exposes stale storage.
  assign out_data = out_valid ? head_vec[lane_cnt] : '0;
  assign out_lane = out_valid ? lane_cnt : '0;
  assign out_last = out_valid && is_last;

endmodule

// File: tb/tb_pe_result_drain.sv
module tb_pe_result_drain;

  localparam int RW  = 16;
  localparam int VEC = 8;
  localparam int DEP = 4;

  typedef logic [VEC-1:0][RW-1:0] vec_t;

  typedef struct {
    logic          iv;
    logic          ordy;
    logic          e_ov;
    logic [RW-1:0] e_dat;
    logic [2:0]    e_lane;
    logic          e_last;
    logic [2:0]    e_lvl;
    logic          e_rdy;
  } rec_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_data [VEC];
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic [2:0]    out_lane;
  logic          out_last;
  logic [2:0]    level;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: queue of stored vectors plus current lane of the head.
  vec_t mq[$];
  int   mlane = 0;

  // Per-step observations for the hand-written sequences.
  logic          last_acc;
  logic          last_beat;
  logic [RW-1:0] last_beat_dat;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_dat;
  logic [2:0]    prev_lane;
  logic          prev_last;

  pe_result_drain #(
    .REG_WIDTH (RW),
    .VECTOR    (VEC),
    .DEPTH     (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mkvec(input int base);
    vec_t v;
    for (int i = 0; i < VEC; i++) v[i] = RW'(base + i);
    return v;
  endfunction

  task automatic drive(input logic iv, input vec_t d, input logic ordy, input logic fl);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    for (int i = 0; i < VEC; i++) in_data[i] = d[i];
  endtask

  // One cycle against the model: drive at negedge, check, clock, update model.
  task automatic step(input logic iv, input vec_t d, input logic ordy, input logic fl);
    logic          e_rdy;
    logic          e_ov;
    logic          e_last;
    logic [RW-1:0] e_dat;
    logic [2:0]    e_lane;
    logic          do_pop;
    drive(iv, d, ordy, fl);
    #1;
    e_rdy  = (mq.size() != DEP) && !fl;
    e_ov   = (mq.size() != 0);
    e_dat  = '0;
    e_lane = '0;
    if (e_ov) begin
      e_dat  = mq[0][mlane];
      e_lane = mlane[2:0];
    end
    e_last = e_ov && (mlane == VEC - 1);
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_ov);
    chk("out_data", out_data, e_dat);
    chk("out_lane", out_lane, e_lane);
    chk("out_last", out_last, e_last);
    chk("level", level, mq.size());
    if (prev_stall) begin
      chk("stall_data", out_data, prev_dat);
      chk("stall_lane", out_lane, prev_lane);
      chk("stall_last", out_last, prev_last);
    end
    last_acc      = iv && e_rdy;
    last_beat     = e_ov && ordy;
    last_beat_dat = out_data;
    prev_stall    = e_ov && !ordy && !fl;
    prev_dat      = out_data;
    prev_lane     = out_lane;
    prev_last     = out_last;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      mlane = 0;
    end else begin
      do_pop = last_beat && e_last;
      if (last_beat) mlane = e_last ? 0 : mlane + 1;
      if (do_pop) void'(mq.pop_front());
      if (last_acc) mq.push_back(d);
    end
    @(negedge clk);
  endtask

  // One table row: drive, compare against the hand-written expectations, clock.
  task automatic apply_rec(input rec_t r, input vec_t d);
    drive(r.iv, d, r.ordy, 1'b0);
    #1;
    chk("tbl_out_valid", out_valid, r.e_ov);
    chk("tbl_out_data", out_data, r.e_dat);
    chk("tbl_out_lane", out_lane, r.e_lane);
    chk("tbl_out_last", out_last, r.e_last);
    chk("tbl_level", level, r.e_lvl);
    chk("tbl_in_ready", in_ready, r.e_rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rec_t tbl [10];
    vec_t v1;
    vec_t z;
    int   k;
    int   acc_c;
    int   nv;
    int   rx;
    int   cyc;

    // Single vector {1..8}, out_ready high: eight beats then empty.
    //            iv ordy ov dat lane last lvl rdy
    tbl[0] = '{1'b1, 1'b1, 1'b0, 16'd0, 3'd0, 1'b0, 3'd0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 16'd1, 3'd0, 1'b0, 3'd1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'd2, 3'd1, 1'b0, 3'd1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'd3, 3'd2, 1'b0, 3'd1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 16'd4, 3'd3, 1'b0, 3'd1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 16'd5, 3'd4, 1'b0, 3'd1, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 16'd6, 3'd5, 1'b0, 3'd1, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'd7, 3'd6, 1'b0, 3'd1, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 16'd8, 3'd7, 1'b1, 3'd1, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 16'd0, 3'd0, 1'b0, 3'd0, 1'b1};
    v1 = mkvec(1);
    z  = '0;

    // Reset state
    rst_n = 1'b0;
    drive(1'b0, z, 1'b0, 1'b0);
    #3;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_lane", out_lane, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_level", level, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single vector
    for (int i = 0; i < 10; i++) apply_rec(tbl[i], v1);

    // Burst of five with consumer stalled: fifth waits for the first pop.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      step(k < 5, mkvec(16'h0A00 + k * 16), 1'b0, 1'b0);
      if (last_acc) k++;
    end
    chk("burst_pushes", k, 4);
    chk("burst_level", level, 4);
    chk("burst_in_ready", in_ready, 0);
    acc_c = -1;
    for (int c = 0; c < 9; c++) begin
      step(1'b1, mkvec(16'h0A00 + k * 16), 1'b1, 1'b0);
      if (last_acc && acc_c < 0) begin
        acc_c = c;
        k++;
      end
    end
    chk("burst_fifth_cycle", acc_c, 8);
    for (int c = 0; c < 40; c++) step(1'b0, z, 1'b1, 1'b0);
    chk("burst_drained", level, 0);

    // Random stalls, 20 incrementing vectors, in-order output.
    nv  = 0;
    rx  = 0;
    cyc = 0;
    while (!(nv == 20 && mq.size() == 0) && cyc < 2000) begin
      step(nv < 20, mkvec(nv * 256), 1'($urandom_range(0, 1)), 1'b0);
      if (last_acc) nv++;
      if (last_beat) begin
        chk("order", last_beat_dat, 32'((rx / 8) * 256 + (rx % 8)));
        rx++;
      end
      cyc++;
    end
    chk("rand_beats", rx, 160);

    // Push coincident with last-beat pop at level 2.
    step(1'b1, mkvec(16'h1100), 1'b0, 1'b0);
    step(1'b1, mkvec(16'h2200), 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) step(1'b0, z, 1'b1, 1'b0);
    chk("coinc_pre_last", out_last, 1);
    chk("coinc_pre_level", level, 2);
    step(1'b1, mkvec(16'h3300), 1'b1, 1'b0);
    chk("coinc_accepted", last_acc, 1);
    chk("coinc_level", level, 2);
    chk("coinc_lane", out_lane, 0);
    chk("coinc_data", out_data, 16'h2200);
    for (int c = 0; c < 20; c++) step(1'b0, z, 1'b1, 1'b0);

    // Flush mid-vector at lane 3, level 3, with a vector offered.
    step(1'b1, mkvec(16'h4400), 1'b0, 1'b0);
    step(1'b1, mkvec(16'h5500), 1'b0, 1'b0);
    step(1'b1, mkvec(16'h6600), 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, z, 1'b1, 1'b0);
    chk("flush_pre_lane", out_lane, 3);
    chk("flush_pre_level", level, 3);
    step(1'b1, mkvec(16'h7700), 1'b1, 1'b1);
    chk("flush_level", level, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_data", out_data, 0);
    step(1'b0, z, 1'b1, 1'b0);
    chk("flush_not_stored", level, 0);

    // Asynchronous reset mid-drain, between edges.
    step(1'b1, mkvec(16'h8800), 1'b0, 1'b0);
    step(1'b1, mkvec(16'h9900), 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, z, 1'b1, 1'b0);
    drive(1'b0, z, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_level", level, 0);
    chk("arst_out_last", out_last, 0);
    mq.delete();
    mlane      = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, mkvec(16'hAA00), 1'b1, 1'b0);
    chk("arst_new_lane", out_lane, 0);
    chk("arst_new_data", out_data, 16'hAA00);
    for (int c = 0; c < 10; c++) step(1'b0, z, 1'b1, 1'b0);
    chk("arst_final_level", level, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
